data_mem_stack: RTL

//   Parametrised data memory for the RNBIP datapath with an integrated hardware stack pointer.

---
 rtl/data_mem_stack_if.sv | 39 +++
 rtl/data_mem_stack.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_stack_if.sv
// ============================================================================
//  Module   : data_mem_stack_if
//  Brief    : Request/response bundle for the data memory with hardware stack.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_mem_stack_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic              src_sel;
    logic [DATA_W-1:0] npc_in;
    logic [DATA_W-1:0] rn_in;
    logic              sp_wr;
    logic [ADDR_W-1:0] sp_wdata;
    logic              clr_flags;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] sp_out;
    logic              ovf;
    logic              unf;

    modport master (
        output req_valid, op, addr, src_sel, npc_in, rn_in, sp_wr, sp_wdata, clr_flags,
        input  req_ready, rd_valid, rd_data, sp_out, ovf, unf
    );

    modport slave (
        input  req_valid, op, addr, src_sel, npc_in, rn_in, sp_wr, sp_wdata, clr_flags,
        output req_ready, rd_valid, rd_data, sp_out, ovf, unf
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_stack.sv
// ============================================================================
//  Module   : data_mem_stack
//  Brief    : Data memory with LOAD/STORE, empty-descending hardware stack and
//             post-reset clear sweep.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_stack #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int SP_INIT     = 255,
    parameter int STACK_LIMIT = 192
) (
    input  wire logic           clk,
    input  wire logic           rst,
    data_mem_stack_if.slave     bus
);

    localparam int                c_depth       = 1 << ADDR_W;
    localparam logic [1:0]        c_op_load     = 2'b00;
    localparam logic [1:0]        c_op_store    = 2'b01;
    localparam logic [1:0]        c_op_push     = 2'b10;
    localparam logic [1:0]        c_op_pop      = 2'b11;
    localparam logic [ADDR_W-1:0] c_sp_init     = ADDR_W'(SP_INIT);
    localparam logic [ADDR_W-1:0] c_stack_limit = ADDR_W'(STACK_LIMIT);
    localparam logic [ADDR_W-1:0] c_last_addr   = ADDR_W'(c_depth - 1);
    localparam logic [ADDR_W-1:0] c_one         = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] r_sp;
    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_unf;

    logic              w_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_wd;
    logic [ADDR_W-1:0] w_sp_inc;
    logic [ADDR_W-1:0] w_sp_dec;
    logic              w_load;
    logic              w_store;
    logic              w_push_ok;
    logic              w_push_rej;
    logic              w_pop_ok;
    logic              w_pop_rej;
    logic              w_sp_load;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + c_one;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_idx == c_last_addr) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // An SP load owns the cycle; a concurrent request stays pending.
                w_ready = !bus.sp_wr;
            end
            default: begin
                w_next_state = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request decode and memory port steering
    // ------------------------------------------------------------------------
    always_comb begin
        w_accept    = bus.req_valid && w_ready;
        w_wd        = bus.src_sel ? bus.rn_in : bus.npc_in;
        w_sp_inc    = r_sp + c_one;
        w_sp_dec    = r_sp - c_one;
        w_load      = w_accept && (bus.op == c_op_load);
        w_store     = w_accept && (bus.op == c_op_store);
        w_push_ok   = w_accept && (bus.op == c_op_push) && (r_sp != c_stack_limit);
        w_push_rej  = w_accept && (bus.op == c_op_push) && (r_sp == c_stack_limit);
        w_pop_ok    = w_accept && (bus.op == c_op_pop)  && (r_sp != c_sp_init);
        w_pop_rej   = w_accept && (bus.op == c_op_pop)  && (r_sp == c_sp_init);
        w_sp_load   = (r_state == ST_IDLE) && bus.sp_wr;

        w_mem_we    = 1'b0;
        w_mem_waddr = r_sp;
        w_mem_wdata = w_wd;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_idx;
            w_mem_wdata = '0;
        end else if (w_store) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = bus.addr;
        end else if (w_push_ok) begin
            w_mem_we    = 1'b1;
        end

        // Empty-descending stack: the top of stack lives one above SP.
        w_rd_en   = w_load || w_pop_ok;
        w_rd_addr = w_load ? bus.addr : w_sp_inc;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read data, stack pointer and sticky flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_sp       <= c_sp_init;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
            if (w_sp_load) begin
                r_sp <= bus.sp_wdata;
            end else if (w_push_ok) begin
                r_sp <= w_sp_dec;
            end else if (w_pop_ok) begin
                r_sp <= w_sp_inc;
            end
            // A flag event in the same cycle as clr_flags leaves the flag set.
            r_ovf <= w_push_rej || (r_ovf && !bus.clr_flags);
            r_unf <= w_pop_rej  || (r_unf && !bus.clr_flags);
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.sp_out    = r_sp;
    assign bus.ovf       = r_ovf;
    assign bus.unf       = r_unf;

endmodule

`default_nettype wire
